if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor to the IF/ID pipeline register. Adds a valid/ready handshake on both sides and a DEPTH-entry instruction queue, so fetch can run ahead of decode.
- Sits between the fetch unit and the decoder. Carries instruction address, instruction word and a fetch-exception tag with its cause.
- Exception-tagged entries are rewritten to NOP at push, and flush empties the queue in one cycle.

Parameters:
- ADDR_WIDTH, 32, instruction address width.
- INST_WIDTH, 32, instruction word width.
- DEPTH, 2, queue entries; legal range 1..16, need not be a power of two.
- NOP_INST, 32'h0000_0013, word substituted for flushed, empty or exception-tagged slots (width INST_WIDTH).
- CAUSE_WIDTH, 4, exception cause width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- flush  in  1  discard all queued entries and any same-cycle push.
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  queue can accept; asserted when count < DEPTH.
- in_addr  in  ADDR_WIDTH  instruction address.
- in_inst  in  INST_WIDTH  instruction word.
- in_exc  in  1  fetch exception raised for this entry.
- in_cause  in  CAUSE_WIDTH  exception cause; ignored when in_exc=0.
- out_valid  out  1  head entry valid (count != 0).
- out_ready  in  1  decode accepts head.
- out_addr  out  ADDR_WIDTH  head address.
- out_inst  out  INST_WIDTH  head instruction; NOP_INST when empty.
- out_exc  out  1  head exception flag; 0 when empty.
- out_cause  out  CAUSE_WIDTH  head cause; 0 when empty or out_exc=0.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_n low, async): count=0, read/write pointers=0, every slot inst=NOP_INST, addr=0, exc=0, cause=0. Resulting outputs: in_ready=1, out_valid=0, out_inst=NOP_INST, out_exc=0, out_cause=0, out_addr=0.
- push = in_valid & in_ready & !flush.
- pop = out_valid & out_ready & !flush.
- in_ready depends only on registered count. There is no combinational path from out_ready to in_ready. When full, no push occurs even if a pop happens in the same cycle.
- Push writes the slot at the write pointer:
  - addr = in_addr.
  - inst = in_exc ? NOP_INST : in_inst.
  - exc = in_exc.
  - cause = in_exc ? in_cause : 0.
- Latency: an entry pushed at edge N appears on out_* with out_valid=1 after edge N (one cycle when empty). Outputs come from registered storage.
- Pointers increment modulo DEPTH with explicit wrap at DEPTH-1. Count changes by +1 on push only, -1 on pop only, and is unchanged on push & pop.
- Push & pop with count=1: the old head leaves and the new entry becomes head next cycle; out_valid stays 1.
- Flush: at the next edge count=0 and both pointers=0. Slot contents are not cleared, but outputs force NOP_INST / exc=0 / cause=0 because count=0. out_addr keeps the head slot's stale address, which is intentional for trap-address capture.
- Flush has priority over push and pop in the same cycle.
- Empty & out_ready=1: no pop, count stays 0.
- in_valid=1 with in_ready=0: the entry is not taken, and fetch must hold it.

Optional Feature:
- Macro IF_ID_QUEUE_PERF_CNT_EN.
- Defined: adds output ports stall_cycles[31:0] and flush_events[31:0], both reset to 0.
  - stall_cycles increments each cycle in_valid & !in_ready.
  - flush_events increments each cycle flush=1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, DEPTH=2: release rst_n -> in_ready=1, out_valid=0, out_inst=32'h0000_0013, count=0.
- Push addr 0x100/inst 0x00500093 with out_ready=0, then addr 0x104/inst 0x00A00113 -> count=2, in_ready=0. Third offer 0x108 is held off. Then out_ready=1 for 2 cycles -> outputs 0x100 then 0x104 in order, then count=0.
- Full queue plus simultaneous in_valid & out_ready -> pop only, count 2->1, 0x108 accepted the following cycle.
- Push in_exc=1, in_cause=4'd1, in_inst=0xDEADBEEF at addr 0x200 -> head shows out_inst=0x00000013, out_exc=1, out_cause=1, out_addr=0x200.
- count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, out_inst=NOP, and the pushed entry is lost.
- DEPTH=3 pointer wrap: 7 back-to-back push/pop pairs with addresses 0x0,0x4,...,0x18 -> output order matches input order and count never exceeds 3. Assert rst_n low mid-stream -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID pipeline stage with valid/ready handshakes on both
// sides and a DEPTH-entry instruction queue between fetch and decode.
// Fetch-exception entries are stored as NOP with their cause preserved.
// A flush empties the queue in a single cycle.
// Optional build macro IF_ID_QUEUE_PERF_CNT_EN adds the stall_cycles and
// flush_events saturating performance counters.
module if_id_queue #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INST_WIDTH  = 32,
    parameter int                    DEPTH       = 2,
    parameter logic [INST_WIDTH-1:0] NOP_INST    = INST_WIDTH'(32'h0000_0013),
    parameter int                    CAUSE_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic [INST_WIDTH-1:0]        in_inst,
    input  logic                         in_exc,
    input  logic [CAUSE_WIDTH-1:0]       in_cause,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic [INST_WIDTH-1:0]        out_inst,
    output logic                         out_exc,
    output logic [CAUSE_WIDTH-1:0]       out_cause,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef IF_ID_QUEUE_PERF_CNT_EN
    ,
    output logic [31:0]                  stall_cycles,
    output logic [31:0]                  flush_events
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Advance a queue pointer, wrapping explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(DEPTH - 1)) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Slot storage.
    logic [ADDR_WIDTH-1:0]  slot_addr_q  [DEPTH];
    logic [INST_WIDTH-1:0]  slot_inst_q  [DEPTH];
    logic                   slot_exc_q   [DEPTH];
    logic [CAUSE_WIDTH-1:0] slot_cause_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic                   push_s;
    logic                   pop_s;
    logic [INST_WIDTH-1:0]  wr_inst_s;
    logic [CAUSE_WIDTH-1:0] wr_cause_s;

    // Handshake qualification: in_ready is a function of registered count only.
    always_comb begin
        in_ready  = (count_q < CNT_W'(DEPTH));
        out_valid = (count_q != CNT_W'(0));
        push_s    = in_valid & in_ready & ~flush;
        pop_s     = out_valid & out_ready & ~flush;
    end

    // Exception-tagged entries are rewritten to NOP; cause only kept when tagged.
    always_comb begin
        if (in_exc) begin
            wr_inst_s  = NOP_INST;
            wr_cause_s = in_cause;
        end else begin
            wr_inst_s  = in_inst;
            wr_cause_s = '0;
        end
    end

    // Next pointers and occupancy; flush overrides any push or pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot storage: written at the write pointer on push; flush leaves contents stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_addr_q[k]  <= '0;
                slot_inst_q[k]  <= NOP_INST;
                slot_exc_q[k]   <= 1'b0;
                slot_cause_q[k] <= '0;
            end
        end else if (push_s) begin
            slot_addr_q[wr_ptr_q]  <= in_addr;
            slot_inst_q[wr_ptr_q]  <= wr_inst_s;
            slot_exc_q[wr_ptr_q]   <= in_exc;
            slot_cause_q[wr_ptr_q] <= wr_cause_s;
        end
    end

    // Head presentation: empty queue shows NOP with no exception; address stays stale
    // so a trap handler can still capture it after a flush.
    always_comb begin
        out_addr = slot_addr_q[rd_ptr_q];
        count    = count_q;
        if (out_valid) begin
            out_inst  = slot_inst_q[rd_ptr_q];
            out_exc   = slot_exc_q[rd_ptr_q];
            out_cause = slot_cause_q[rd_ptr_q];
        end else begin
            out_inst  = NOP_INST;
            out_exc   = 1'b0;
            out_cause = '0;
        end
    end

`ifdef IF_ID_QUEUE_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    // Saturating counters for fetch back-pressure cycles and flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            if (in_valid && !in_ready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (flush && (flush_events_q != 32'hFFFF_FFFF)) begin
                flush_events_q <= flush_events_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue. Two instances (DEPTH=2 and DEPTH=3)
// share one input stream. Each instance is compared against its own
// queue-based reference model.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        exc;
        logic [3:0]  cause;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_addr;
    logic [31:0] in_inst;
    logic        in_exc;
    logic [3:0]  in_cause;
    logic        out_ready;

    logic        in_ready2, out_valid2, out_exc2;
    logic [31:0] out_addr2, out_inst2;
    logic [3:0]  out_cause2;
    logic [1:0]  count2;
    logic        in_ready3, out_valid3, out_exc3;
    logic [31:0] out_addr3, out_inst3;
    logic [3:0]  out_cause3;
    logic [1:0]  count3;
`ifdef IF_ID_QUEUE_PERF_CNT_EN
    logic [31:0] stall2, flushes2, stall3, flushes3;
    int          m_stall2, m_stall3, m_flushes;
`endif

    int   n_assert;
    int   n_fail;
    ent_t q2[$];
    ent_t q3[$];

    if_id_queue #(.DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_addr(in_addr),
        .in_inst(in_inst), .in_exc(in_exc), .in_cause(in_cause),
        .out_valid(out_valid2), .out_ready(out_ready), .out_addr(out_addr2),
        .out_inst(out_inst2), .out_exc(out_exc2), .out_cause(out_cause2),
        .count(count2)
`ifdef IF_ID_QUEUE_PERF_CNT_EN
        , .stall_cycles(stall2), .flush_events(flushes2)
`endif
    );

    if_id_queue #(.DEPTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3), .in_addr(in_addr),
        .in_inst(in_inst), .in_exc(in_exc), .in_cause(in_cause),
        .out_valid(out_valid3), .out_ready(out_ready), .out_addr(out_addr3),
        .out_inst(out_inst3), .out_exc(out_exc3), .out_cause(out_cause3),
        .count(count3)
`ifdef IF_ID_QUEUE_PERF_CNT_EN
        , .stall_cycles(stall3), .flush_events(flushes3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare one instance's visible state against the model's queue contents.
    task automatic chk_dut(input string t, input int sz, input int depth, input ent_t head,
                           input logic ir, input logic ov, input logic [31:0] oa,
                           input logic [31:0] oi, input logic oe, input logic [3:0] oc,
                           input logic [1:0] cnt);
        chk({t, ".in_ready"},  64'(ir),  64'(sz < depth));
        chk({t, ".out_valid"}, 64'(ov),  64'(sz != 0));
        chk({t, ".count"},     64'(cnt), 64'(sz));
        chk({t, ".out_inst"},  64'(oi),  (sz != 0) ? 64'(head.inst) : 64'(NOP));
        chk({t, ".out_exc"},   64'(oe),  (sz != 0) ? 64'(head.exc) : 64'd0);
        chk({t, ".out_cause"}, 64'(oc),  (sz != 0) ? 64'(head.cause) : 64'd0);
        if (sz != 0) begin
            chk({t, ".out_addr"}, 64'(oa), 64'(head.addr));
        end
    endtask

    task automatic check_all();
        ent_t h2;
        ent_t h3;
        h2 = (q2.size() != 0) ? q2[0] : '0;
        h3 = (q3.size() != 0) ? q3[0] : '0;
        chk_dut("d2", q2.size(), 2, h2, in_ready2, out_valid2, out_addr2,
                out_inst2, out_exc2, out_cause2, count2);
        chk_dut("d3", q3.size(), 3, h3, in_ready3, out_valid3, out_addr3,
                out_inst3, out_exc3, out_cause3, count3);
`ifdef IF_ID_QUEUE_PERF_CNT_EN
        chk("d2.stall_cycles", 64'(stall2),   64'(m_stall2));
        chk("d3.stall_cycles", 64'(stall3),   64'(m_stall3));
        chk("d2.flush_events", 64'(flushes2), 64'(m_flushes));
        chk("d3.flush_events", 64'(flushes3), 64'(m_flushes));
`endif
    endtask

    // Reset outputs that hold whether or not the model queue is empty.
    task automatic check_reset_addr();
        chk("d2.reset_out_addr", 64'(out_addr2), 64'd0);
        chk("d3.reset_out_addr", 64'(out_addr3), 64'd0);
    endtask

    // One clock cycle: drive at negedge, check, advance the models at posedge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] i,
                         input logic e, input logic [3:0] c, input logic ordy,
                         input logic fl);
        ent_t ent;
        logic push2, pop2, push3, pop3;
        in_valid  = v;
        in_addr   = a;
        in_inst   = i;
        in_exc    = e;
        in_cause  = c;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_all();
        ent.addr  = a;
        ent.inst  = e ? NOP : i;
        ent.exc   = e;
        ent.cause = e ? c : 4'd0;
        push2 = v && (q2.size() < 2) && !fl;
        pop2  = ordy && (q2.size() > 0) && !fl;
        push3 = v && (q3.size() < 3) && !fl;
        pop3  = ordy && (q3.size() > 0) && !fl;
`ifdef IF_ID_QUEUE_PERF_CNT_EN
        if (v && q2.size() >= 2) m_stall2++;
        if (v && q3.size() >= 3) m_stall3++;
        if (fl) m_flushes++;
`endif
        @(posedge clk);
        if (fl) begin
            q2.delete();
            q3.delete();
        end else begin
            if (pop2)  void'(q2.pop_front());
            if (push2) q2.push_back(ent);
            if (pop3)  void'(q3.pop_front());
            if (push3) q3.push_back(ent);
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        q2.delete();
        q3.delete();
`ifdef IF_ID_QUEUE_PERF_CNT_EN
        m_stall2  = 0;
        m_stall3  = 0;
        m_flushes = 0;
`endif
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_addr   = 32'd0;
        in_inst   = 32'd0;
        in_exc    = 1'b0;
        in_cause  = 4'd0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        check_reset_addr();
        rst_n = 1'b1;

        // Fill with out_ready low; third offer is held off by the DEPTH=2 queue.
        cycle(1'b1, 32'h100, 32'h0050_0093, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'h104, 32'h00A0_0113, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'h108, 32'h0000_0193, 1'b0, 4'd0, 1'b0, 1'b0);
        // Full plus simultaneous in_valid & out_ready: pop only, 0x108 taken next cycle.
        cycle(1'b1, 32'h108, 32'h0000_0193, 1'b0, 4'd0, 1'b1, 1'b0);
        cycle(1'b1, 32'h108, 32'h0000_0193, 1'b0, 4'd0, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);

        // Exception-tagged entry is rewritten to NOP with cause kept.
        cycle(1'b1, 32'h200, 32'hDEAD_BEEF, 1'b1, 4'd1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);

        // Flush with a same-cycle push: everything is discarded.
        cycle(1'b1, 32'h300, 32'h0000_0213, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 32'h0000_0293, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'h308, 32'h0000_0313, 1'b0, 4'd0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Back-to-back push/pop pairs drive the pointers through several wraps.
        for (int k = 0; k < 8; k++) begin
            cycle(k < 7, 32'(k * 4), 32'h0100_0013 + 32'(k), 1'b0, 4'd0, 1'b1, 1'b0);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);

        // Randomised traffic with occasional flushes and exceptions.
        for (int k = 0; k < 300; k++) begin
            cycle($urandom_range(3, 0) != 0, $urandom, $urandom,
                  $urandom_range(7, 0) == 0, 4'($urandom), $urandom_range(1, 0) == 1,
                  $urandom_range(15, 0) == 0);
        end

        // Asynchronous reset mid-stream: outputs clear before any clock edge.
        cycle(1'b1, 32'h400, 32'h0000_0393, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'h404, 32'h0000_0413, 1'b1, 4'd3, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check_reset_addr();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 32'h500, 32'h0000_0493, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
